// File: rtl/core_axi_bridge.sv
// Bus interface unit between the pipeline core and a single AXI4-Lite master port.
// Arbitrates fetch and load/store requests, one outstanding access at a time.
module core_axi_bridge #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned STRB_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_rd_en_i,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic                mem_rd_en_i,
  input  logic [ADDR_W-1:0]   addr_mem_rd_i,
  input  logic                mem_wr_en_i,
  input  logic [ADDR_W-1:0]   addr_mem_wr_i,
  input  logic [DATA_W-1:0]   data_mem_wr_i,
  input  logic [STRB_W-1:0]   strb_mem_wr_i,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [DATA_W-1:0]   data_mem_o,
  output logic                stall_if_o,
  output logic                stall_mem_o,
  output logic                bus_err_o,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [STRB_W-1:0]   m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned WORD_LSB = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_RD_A  = 3'd1;
  localparam logic [STATE_W-1:0] S_RD_D  = 3'd2;
  localparam logic [STATE_W-1:0] S_WR_AW = 3'd3;
  localparam logic [STATE_W-1:0] S_WR_B  = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

  localparam logic TAG_DATA  = 1'b0;
  localparam logic TAG_INSTR = 1'b1;

  logic [STATE_W-1:0] state_q, state_d;
  logic               tag_q, tag_d;
  logic               pc_hi_q, pc_hi_d;

  logic [ADDR_W-1:0]  araddr_d, awaddr_d;
  logic [DATA_W-1:0]  wdata_d, data_mem_d;
  logic [STRB_W-1:0]  wstrb_d;
  logic [INSTR_W-1:0] instr_d;
  logic               arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d, bus_err_d;

  logic               done_data_c, done_instr_c;
  logic               unused_pc_lsb;

  assign unused_pc_lsb = ^pc_i[1:0];

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    pc_hi_d    = pc_hi_q;
    araddr_d   = m_araddr;
    awaddr_d   = m_awaddr;
    wdata_d    = m_wdata;
    wstrb_d    = m_wstrb;
    data_mem_d = data_mem_o;
    instr_d    = instr_o;
    arvalid_d  = m_arvalid;
    rready_d   = m_rready;
    awvalid_d  = m_awvalid;
    wvalid_d   = m_wvalid;
    bready_d   = m_bready;
    bus_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Data beats fetch; among data requests the store wins
        if (mem_wr_en_i) begin
          state_d   = S_WR_AW;
          tag_d     = TAG_DATA;
          awaddr_d  = addr_mem_wr_i;
          wdata_d   = data_mem_wr_i;
          wstrb_d   = strb_mem_wr_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else if (mem_rd_en_i) begin
          state_d   = S_RD_A;
          tag_d     = TAG_DATA;
          araddr_d  = addr_mem_rd_i;
          arvalid_d = 1'b1;
        end else if (instr_rd_en_i) begin
          state_d   = S_RD_A;
          tag_d     = TAG_INSTR;
          araddr_d  = {pc_i[ADDR_W-1:WORD_LSB], 3'b000};
          pc_hi_d   = pc_i[2];
          arvalid_d = 1'b1;
        end
      end

      S_RD_A: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_D;
        end
      end

      S_RD_D: begin
        if (m_rvalid) begin
          rready_d  = 1'b0;
          state_d   = S_DONE;
          bus_err_d = (m_rresp != 2'b00);
          if (tag_q == TAG_INSTR) begin
            instr_d = pc_hi_q ? m_rdata[2*INSTR_W-1:INSTR_W] : m_rdata[INSTR_W-1:0];
          end else begin
            data_mem_d = m_rdata;
          end
        end
      end

      S_WR_AW: begin
        // Address and data channels retire independently
        if (m_awready) awvalid_d = 1'b0;
        if (m_wready)  wvalid_d  = 1'b0;
        if ((~m_awvalid | m_awready) & (~m_wvalid | m_wready)) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end

      S_WR_B: begin
        if (m_bvalid) begin
          bready_d  = 1'b0;
          state_d   = S_DONE;
          bus_err_d = (m_bresp != 2'b00);
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tag_q      <= TAG_DATA;
      pc_hi_q    <= 1'b0;
      m_araddr   <= '0;
      m_awaddr   <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      data_mem_o <= '0;
      instr_o    <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      pc_hi_q    <= pc_hi_d;
      m_araddr   <= araddr_d;
      m_awaddr   <= awaddr_d;
      m_wdata    <= wdata_d;
      m_wstrb    <= wstrb_d;
      data_mem_o <= data_mem_d;
      instr_o    <= instr_d;
      m_arvalid  <= arvalid_d;
      m_rready   <= rready_d;
      m_awvalid  <= awvalid_d;
      m_wvalid   <= wvalid_d;
      m_bready   <= bready_d;
      bus_err_o  <= bus_err_d;
    end
  end

  // Stalls release only in the DONE cycle of the owning requester
  assign done_data_c  = (state_q == S_DONE) & (tag_q == TAG_DATA);
  assign done_instr_c = (state_q == S_DONE) & (tag_q == TAG_INSTR);
  assign stall_mem_o  = (mem_rd_en_i | mem_wr_en_i) & ~done_data_c;
  assign stall_if_o   = instr_rd_en_i & ~done_instr_c;

endmodule

// File: tb/tb_core_axi_bridge.sv
// Bench for core_axi_bridge: AXI4-Lite slave with programmable wait states and a
// word-level memory model that predicts load/fetch data, latency and errors.
module tb_core_axi_bridge;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_rd_en_i, mem_rd_en_i, mem_wr_en_i;
  logic [63:0] pc_i, addr_mem_rd_i, addr_mem_wr_i, data_mem_wr_i;
  logic [7:0]  strb_mem_wr_i;
  logic [31:0] instr_o;
  logic [63:0] data_mem_o;
  logic        stall_if_o, stall_mem_o, bus_err_o;
  logic [63:0] m_awaddr, m_wdata, m_araddr;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [7:0]  m_wstrb;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic        m_arready = 1'b0, m_rvalid = 1'b0;
  logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
  logic [63:0] m_rdata = 64'h0;

  int checks = 0;
  int failures = 0;

  int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;

  logic [63:0] slv_mem [logic [60:0]];
  logic [63:0] ref_mem [logic [60:0]];
  logic [63:0] ar_log[$];
  logic [63:0] aw_log[$];
  logic [7:0]  w_log[$];
  logic        arv_hist [0:127];
  logic        awv_hist [0:127];
  logic        wv_hist  [0:127];

  core_axi_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .instr_rd_en_i(instr_rd_en_i), .pc_i(pc_i),
    .mem_rd_en_i(mem_rd_en_i), .addr_mem_rd_i(addr_mem_rd_i),
    .mem_wr_en_i(mem_wr_en_i), .addr_mem_wr_i(addr_mem_wr_i),
    .data_mem_wr_i(data_mem_wr_i), .strb_mem_wr_i(strb_mem_wr_i),
    .instr_o(instr_o), .data_mem_o(data_mem_o),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .bus_err_o(bus_err_o),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input logic [60:0] k);
    return {k[31:0] ^ 32'hC0DE_F00D, ~k[31:0]};
  endfunction

  function automatic logic [63:0] slv_rd(input logic [60:0] k);
    if (slv_mem.exists(k)) return slv_mem[k];
    return init_word(k);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [60:0] k);
    if (ref_mem.exists(k)) return ref_mem[k];
    return init_word(k);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] w;
    w = old;
    for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Handshakes seen at each rising edge
  logic        ar_hs = 1'b0, r_hs = 1'b0, aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0;
  logic [63:0] hs_araddr = 64'h0, hs_awaddr = 64'h0, hs_wdata = 64'h0;
  initial forever begin
    @(posedge clk);
    ar_hs = m_arvalid & m_arready;
    r_hs  = m_rvalid & m_rready;
    aw_hs = m_awvalid & m_awready;
    w_hs  = m_wvalid & m_wready;
    b_hs  = m_bvalid & m_bready;
    if (ar_hs) begin hs_araddr = m_araddr; ar_log.push_back(m_araddr); end
    if (aw_hs) begin hs_awaddr = m_awaddr; aw_log.push_back(m_awaddr); end
    if (w_hs)  begin hs_wdata = m_wdata; w_log.push_back(m_wstrb); end
  end

  // Slave responder, driven on the falling edge
  int   ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic r_pend = 1'b0, aw_done = 1'b0, w_done = 1'b0;
  logic [7:0] wstrb_cap = 8'h0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      r_pend = 0; aw_done = 0; w_done = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (r_hs) m_rvalid = 0;
      if (ar_hs) begin
        m_arready = 0; r_pend = 1; r_cnt = 0;
      end else if (m_arvalid && !m_arready && !r_pend) begin
        if (ar_cnt >= ar_lat) begin m_arready = 1; ar_cnt = 0; end else ar_cnt++;
      end
      if (r_pend && !m_rvalid) begin
        if (r_cnt >= r_lat) begin
          m_rvalid = 1; m_rdata = slv_rd(hs_araddr[63:3]); m_rresp = rresp_cfg; r_pend = 0; r_cnt = 0;
        end else r_cnt++;
      end
      if (b_hs) m_bvalid = 0;
      if (aw_hs) begin
        m_awready = 0; aw_done = 1;
      end else if (m_awvalid && !m_awready && !aw_done) begin
        if (aw_cnt >= aw_lat) begin m_awready = 1; aw_cnt = 0; end else aw_cnt++;
      end
      if (w_hs) begin
        m_wready = 0; w_done = 1; wstrb_cap = w_log[$];
      end else if (m_wvalid && !m_wready && !w_done) begin
        if (w_cnt >= w_lat) begin m_wready = 1; w_cnt = 0; end else w_cnt++;
      end
      if (aw_done && w_done && !m_bvalid) begin
        if (b_cnt >= b_lat) begin
          m_bvalid = 1; m_bresp = bresp_cfg; aw_done = 0; w_done = 0; b_cnt = 0;
          if (bresp_cfg == 2'b00)
            slv_mem[hs_awaddr[63:3]] = merge(slv_rd(hs_awaddr[63:3]), hs_wdata, wstrb_cap);
        end else b_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic wait_stall(input int which, output int j);
    bit seen;
    seen = 0;
    j = 0;
    arv_hist[0] = m_arvalid; awv_hist[0] = m_awvalid; wv_hist[0] = m_wvalid;
    while (!seen && j < TMO) begin
      @(negedge clk);
      j++;
      arv_hist[j] = m_arvalid; awv_hist[j] = m_awvalid; wv_hist[j] = m_wvalid;
      if (which == 0 ? !stall_mem_o : !stall_if_o) seen = 1;
    end
    chk("stall_release_seen", 64'(seen), 64'h1);
  endtask

  // op: 0 load, 1 store, 2 fetch
  task automatic do_op(input int op, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [7:0] st, input bit keep);
    int j, exp_lat;
    logic exp_err;
    logic [63:0] word;
    if (op == 1) begin
      exp_lat = 3 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat;
      exp_err = (bresp_cfg != 2'b00);
      addr_mem_wr_i = addr; data_mem_wr_i = wd; strb_mem_wr_i = st; mem_wr_en_i = 1;
    end else begin
      exp_lat = 3 + ar_lat + r_lat;
      exp_err = (rresp_cfg != 2'b00);
      if (op == 0) begin addr_mem_rd_i = addr; mem_rd_en_i = 1; end
      else begin pc_i = addr; instr_rd_en_i = 1; end
    end
    wait_stall(op == 2 ? 1 : 0, j);
    chk("latency", 64'(j), 64'(exp_lat));
    chk("bus_err_at_done", 64'(bus_err_o), 64'(exp_err));
    word = ref_rd(addr[63:3]);
    if (op == 0) begin
      chk("load_data", data_mem_o, word);
      chk("load_araddr", ar_log[$], addr);
    end else if (op == 2) begin
      chk("instr", 64'(instr_o), 64'(addr[2] ? word[63:32] : word[31:0]));
      chk("fetch_araddr", ar_log[$], {addr[63:3], 3'b000});
    end else begin
      chk("wstrb", 64'(w_log[$]), 64'(st));
      chk("awaddr", aw_log[$], addr);
      if (!exp_err) ref_mem[addr[63:3]] = merge(word, wd, st);
    end
    if (!keep) begin mem_rd_en_i = 0; mem_wr_en_i = 0; instr_rd_en_i = 0; end
    @(negedge clk);
    chk("bus_err_pulse_end", 64'(bus_err_o), 64'h0);
  endtask

  task automatic preload(input logic [63:0] addr, input logic [63:0] val);
    slv_mem[addr[63:3]] = val;
    ref_mem[addr[63:3]] = val;
  endtask

  initial begin
    int j;
    logic [63:0] a, p, d;
    rst_n = 0;
    instr_rd_en_i = 0; mem_rd_en_i = 0; mem_wr_en_i = 0;
    pc_i = 0; addr_mem_rd_i = 0; addr_mem_wr_i = 0; data_mem_wr_i = 0; strb_mem_wr_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 64'(m_arvalid), 64'h0);
    chk("rst_awvalid", 64'(m_awvalid), 64'h0);
    chk("rst_wvalid", 64'(m_wvalid), 64'h0);
    chk("rst_readies", 64'({m_rready, m_bready}), 64'h0);
    chk("rst_instr", 64'(instr_o), 64'h0);
    chk("rst_data", data_mem_o, 64'h0);
    chk("rst_bus_err", 64'(bus_err_o), 64'h0);
    chk("rst_stalls", 64'({stall_if_o, stall_mem_o}), 64'h0);
    rst_n = 1;
    @(negedge clk);

    // Zero-wait load
    preload(64'h8000_0010, 64'h1122_3344_5566_7788);
    do_op(0, 64'h8000_0010, 64'h0, 8'h0, 0);
    chk("load_arvalid_n0", 64'(arv_hist[0]), 64'h0);
    chk("load_arvalid_n1", 64'(arv_hist[1]), 64'h1);
    chk("load_value_lit", data_mem_o, 64'h1122_3344_5566_7788);

    // Fetch of the upper instruction word, stall low for one cycle only
    preload(64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD);
    do_op(2, 64'h8000_0004, 64'h0, 8'h0, 1);
    chk("fetch_stall_reasserted", 64'(stall_if_o), 64'h1);
    chk("fetch_instr_lit", 64'(instr_o), 64'hAAAA_BBBB);
    instr_rd_en_i = 0;
    @(negedge clk);

    // Store with skewed channels
    aw_lat = 0; w_lat = 3; b_lat = 1;
    do_op(1, 64'h8000_0100, 64'hDEAD_BEEF_0BAD_F00D, 8'h0F, 0);
    chk("st_awvalid_n1", 64'(awv_hist[1]), 64'h1);
    chk("st_awvalid_n2", 64'(awv_hist[2]), 64'h0);
    chk("st_wvalid_n4", 64'(wv_hist[4]), 64'h1);
    chk("st_wvalid_n5", 64'(wv_hist[5]), 64'h0);
    aw_lat = 0; w_lat = 0; b_lat = 0;
    do_op(0, 64'h8000_0100, 64'h0, 8'h0, 0);

    // Simultaneous fetch and load: load first, fetch stays stalled through its DONE
    a = 64'h8000_0020; p = 64'h8000_0034;
    addr_mem_rd_i = a; mem_rd_en_i = 1; pc_i = p; instr_rd_en_i = 1;
    wait_stall(0, j);
    chk("both_load_lat", 64'(j), 64'h3);
    chk("both_if_stalled", 64'(stall_if_o), 64'h1);
    chk("both_load_data", data_mem_o, ref_rd(a[63:3]));
    chk("both_load_first", ar_log[$], a);
    mem_rd_en_i = 0;
    wait_stall(1, j);
    chk("both_fetch_lat", 64'(j), 64'h4);
    d = ref_rd(p[63:3]);
    chk("both_fetch_instr", 64'(instr_o), 64'(d[63:32]));
    chk("both_fetch_addr", ar_log[$], {p[63:3], 3'b000});
    instr_rd_en_i = 0;
    @(negedge clk);

    // Error response on a load
    rresp_cfg = 2'b10;
    do_op(0, 64'h8000_0038, 64'h0, 8'h0, 0);
    rresp_cfg = 2'b00;
    do_op(0, 64'h8000_0038, 64'h0, 8'h0, 0);

    // Flush: load withdrawn while waiting for arready
    ar_lat = 2;
    a = 64'h8000_0048;
    addr_mem_rd_i = a; mem_rd_en_i = 1;
    repeat (2) @(negedge clk);
    mem_rd_en_i = 0;
    #1 chk("flush_no_stall", 64'(stall_mem_o), 64'h0);
    repeat (6) @(negedge clk);
    chk("flush_captured", data_mem_o, ref_rd(a[63:3]));
    chk("flush_idle_valids", 64'({m_arvalid, m_rready}), 64'h0);
    chk("flush_araddr", ar_log[$], a);
    ar_lat = 0;

    // Async reset while arvalid waits for arready
    ar_lat = 30;
    p = 64'h8000_0060;
    pc_i = p; instr_rd_en_i = 1;
    repeat (2) @(negedge clk);
    chk("pre_rst_arvalid", 64'(m_arvalid), 64'h1);
    #2 rst_n = 0;
    #1 chk("rst_mid_arvalid", 64'(m_arvalid), 64'h0);
    chk("rst_mid_rready", 64'(m_rready), 64'h0);
    chk("rst_mid_stall_if", 64'(stall_if_o), 64'h1);
    @(negedge clk);
    ar_lat = 0;
    @(negedge clk);
    rst_n = 1;
    wait_stall(1, j);
    chk("reissue_lat", 64'(j), 64'h3);
    d = ref_rd(p[63:3]);
    chk("reissue_instr", 64'(instr_o), 64'(d[31:0]));
    chk("reissue_addr", ar_log[$], p);
    instr_rd_en_i = 0;
    @(negedge clk);

    // Randomized mix of loads, stores and fetches over a small address window
    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      ar_lat = int'($urandom_range(0, 3)); r_lat = int'($urandom_range(0, 3));
      aw_lat = int'($urandom_range(0, 3)); w_lat = int'($urandom_range(0, 3));
      b_lat = int'($urandom_range(0, 3));
      rresp_cfg = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'b00;
      a = 64'h8000_0200 + 64'(8 * $urandom_range(0, 5));
      if (op == 2) a = a + 64'(4 * $urandom_range(0, 1));
      d = {$urandom, $urandom};
      do_op(op, a, d, 8'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
